// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter onto a single line-wide memory interface
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // port 0: instruction cache
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic [LINE_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    // port 1: data cache
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic [LINE_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    // memory side
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    // debug
    output logic [1:0]        grant_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT0  = 2'd1;
    localparam logic [1:0] S_GRANT1  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        r_state;
    logic              r_prio;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;
    logic [1:0]        r_grant;

    logic              w_pick0;
    logic              w_pick1;
    logic              w_contended;
    logic              w_ack0;
    logic              w_ack1;

    // Grant decision in IDLE: a lone requester wins outright, a tie goes to the prio port
    always_comb begin
        w_pick0     = 1'b0;
        w_pick1     = 1'b0;
        w_contended = p0_enable_i && p1_enable_i;
        if (r_state == S_IDLE) begin
            if (w_contended) begin
                w_pick0 = ~r_prio;
                w_pick1 = r_prio;
            end else begin
                w_pick0 = p0_enable_i;
                w_pick1 = p1_enable_i;
            end
        end
    end

    // Owner handshake: the ack and read data pass straight through, zero otherwise
    always_comb begin
        w_ack0    = (r_state == S_GRANT0) && mem_ack_i;
        w_ack1    = (r_state == S_GRANT1) && mem_ack_i;
        p0_ack_o  = w_ack0;
        p1_ack_o  = w_ack1;
        p0_data_o = w_ack0 ? mem_data_i : '0;
        p1_data_o = w_ack1 ? mem_data_i : '0;
    end

    // State, priority pointer and the captured request presented to memory
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_grant      <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick0) begin
                        r_state      <= S_GRANT0;
                        r_mem_enable <= p0_enable_i;
                        r_mem_write  <= p0_write_i;
                        r_mem_addr   <= p0_addr_i;
                        r_mem_data   <= p0_data_i;
                        r_grant      <= 2'b01;
                    end else if (w_pick1) begin
                        r_state      <= S_GRANT1;
                        r_mem_enable <= p1_enable_i;
                        r_mem_write  <= p1_write_i;
                        r_mem_addr   <= p1_addr_i;
                        r_mem_data   <= p1_data_i;
                        r_grant      <= 2'b10;
                    end
                    // The pointer only moves when a tie was actually broken
                    if (w_contended) begin
                        r_prio <= ~r_prio;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    // Address and data stay as latched; requester changes are ignored
                    if (mem_ack_i) begin
                        r_state      <= S_RELEASE;
                        r_mem_enable <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_grant      <= 2'b00;
                    end
                end
                default: begin
                    // Dead cycle lets the acked requester drop enable before we look again
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign grant_o      = r_grant;

endmodule
